// File: rtl/velocity_pkg.sv
// velocity_pkg: shared types for the Doppler velocity moving-average filter.
// Holds the sample width, the signed velocity type and the filter FSM states.
package velocity_pkg;

    localparam int VEL_W = 17;

    typedef logic signed [VEL_W-1:0] vel_t;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_STEADY,
        ST_FLUSH
    } vf_state_t;

endpackage

// File: rtl/vel_ring_buffer.sv
// vel_ring_buffer: DEPTH-entry circular sample store with wrapping write pointer.
// Presents the entry about to be overwritten so the parent can retire it from the sum.
module vel_ring_buffer
    import velocity_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          wr_en,
    input  vel_t          wr_data,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_idx,
    input  logic          ptr_clr,
    output vel_t          rd_data
);

    vel_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr;

    assign rd_data = mem_q[wr_ptr];

    // Entry storage: flush clears by index, normal writes go to wr_ptr.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clr_en) begin
            mem_q[clr_idx] <= '0;
        end else if (wr_en) begin
            mem_q[wr_ptr] <= wr_data;
        end
    end

    // Write pointer advances per stored sample and wraps DEPTH-1 -> 0.
    always_ff @(posedge clk_in) begin
        if (rst_in || ptr_clr) begin
            wr_ptr <= '0;
        end else if (wr_en) begin
            if (int'(wr_ptr) == DEPTH - 1) begin
                wr_ptr <= '0;
            end else begin
                wr_ptr <= wr_ptr + AW'(1);
            end
        end
    end

endmodule

// File: rtl/velocity_filter.sv
// velocity_filter: signed moving average of Doppler speed samples with timeout flush.
// Optional outlier rejection in steady state is enabled by VELOCITY_OUTLIER_REJECT_EN.
module velocity_filter
    import velocity_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 100_000_000,
    parameter int OUTLIER_THRESH = 50
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         doppler_ready,
    input  logic [15:0]  velocity_in,
    input  logic         towards_in,
    output vel_t         avg_out,
    output logic         avg_valid_out,
    output logic         full_out,
    output logic         stale_out,
    output logic [7:0]   reject_cnt_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = VEL_W + AW;
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

    vf_state_t               state;
    logic signed [SW-1:0]    sum_q;
    logic signed [SW-1:0]    sum_nxt;
    logic signed [SW-1:0]    sum_shr;
    logic [AW:0]             fill_cnt;
    logic [AW-1:0]           flush_cnt;
    logic [IW-1:0]           idle_cnt;
    logic [VEL_W-1:0]        mag;
    vel_t                    s;
    vel_t                    old_s;
    vel_t                    avg_nxt;
    logic                    accept;
    logic                    reject;
    logic                    timed_out;

    // Sign the magnitude by direction; approaching targets are positive.
    always_comb begin
        mag = {1'b0, velocity_in};
        s   = towards_in ? vel_t'(mag) : vel_t'(-mag);
    end

    // Running sum swaps the oldest entry for the new one; average is a shift.
    always_comb begin
        sum_nxt = sum_q
                + {{AW{s[VEL_W-1]}}, s}
                - {{AW{old_s[VEL_W-1]}}, old_s};
        sum_shr = sum_nxt >>> AW;
        avg_nxt = sum_shr[VEL_W-1:0];
    end

`ifdef VELOCITY_OUTLIER_REJECT_EN
    logic signed [VEL_W:0] dev;
    logic [VEL_W:0]        dev_abs;
    logic [1:0]            rej_run;
    logic [7:0]            rej_cnt;

    // Outliers are judged against the published average; every 4th in a row gets through.
    always_comb begin
        dev     = $signed({s[VEL_W-1], s}) - $signed({avg_out[VEL_W-1], avg_out});
        dev_abs = dev[VEL_W] ? $unsigned(-dev) : $unsigned(dev);
        reject  = doppler_ready
                && (state == ST_STEADY)
                && (int'(dev_abs) > OUTLIER_THRESH)
                && (rej_run != 2'd3);
    end

    // Consecutive-reject run length and saturating total reject count.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rej_run <= '0;
            rej_cnt <= '0;
        end else if (reject) begin
            rej_run <= rej_run + 2'd1;
            if (rej_cnt != 8'hFF) begin
                rej_cnt <= rej_cnt + 8'd1;
            end
        end else if (accept) begin
            rej_run <= '0;
        end
    end

    assign reject_cnt_out = rej_cnt;
`else
    assign reject         = 1'b0;
    assign reject_cnt_out = '0;
`endif

    assign accept    = doppler_ready && (state != ST_FLUSH) && !reject;
    assign timed_out = (idle_cnt == IW'(TIMEOUT_CYCLES));

    vel_ring_buffer #(
        .DEPTH   (DEPTH)
    ) u_ring (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .wr_en   (accept),
        .wr_data (s),
        .clr_en  (state == ST_FLUSH),
        .clr_idx (flush_cnt),
        .ptr_clr (state == ST_FLUSH),
        .rd_data (old_s)
    );

    // Filter FSM: fill the window, run steady, flush on idle timeout.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state         <= ST_FILL;
            sum_q         <= '0;
            fill_cnt      <= '0;
            flush_cnt     <= '0;
            idle_cnt      <= '0;
            avg_out       <= '0;
            avg_valid_out <= 1'b0;
            full_out      <= 1'b0;
            stale_out     <= 1'b0;
        end else begin
            avg_valid_out <= 1'b0;
            unique case (state)
                ST_FLUSH: begin
                    idle_cnt  <= '0;
                    flush_cnt <= flush_cnt + AW'(1);
                    if (int'(flush_cnt) == DEPTH - 1) begin
                        flush_cnt <= '0;
                        state     <= ST_FILL;
                    end
                end
                ST_FILL, ST_STEADY: begin
                    if (accept) begin
                        sum_q         <= sum_nxt;
                        avg_out       <= avg_nxt;
                        avg_valid_out <= 1'b1;
                        idle_cnt      <= '0;
                        stale_out     <= 1'b0;
                        if (state == ST_FILL) begin
                            fill_cnt <= fill_cnt + (AW+1)'(1);
                            if (int'(fill_cnt) == DEPTH - 1) begin
                                state    <= ST_STEADY;
                                full_out <= 1'b1;
                            end
                        end
                    end else if (timed_out) begin
                        state     <= ST_FLUSH;
                        stale_out <= 1'b1;
                        sum_q     <= '0;
                        fill_cnt  <= '0;
                        flush_cnt <= '0;
                        idle_cnt  <= '0;
                        full_out  <= 1'b0;
                        avg_out   <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + IW'(1);
                    end
                end
                default: begin
                    state <= ST_FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_velocity_filter.sv
// tb_velocity_filter: directed self-checking bench for velocity_filter.
// DEPTH=8, TIMEOUT_CYCLES=1000, OUTLIER_THRESH=50.
module tb_velocity_filter;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        doppler_ready = 1'b0;
    logic [15:0] velocity_in = '0;
    logic        towards_in = 1'b0;
    logic signed [16:0] avg_out;
    logic        avg_valid_out;
    logic        full_out;
    logic        stale_out;
    logic [7:0]  reject_cnt_out;

    int checks = 0;
    int errors = 0;

    velocity_filter #(
        .DEPTH          (8),
        .TIMEOUT_CYCLES (1000),
        .OUTLIER_THRESH (50)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .doppler_ready  (doppler_ready),
        .velocity_in    (velocity_in),
        .towards_in     (towards_in),
        .avg_out        (avg_out),
        .avg_valid_out  (avg_valid_out),
        .full_out       (full_out),
        .stale_out      (stale_out),
        .reject_cnt_out (reject_cnt_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Strobe one sample; returns on the negedge after the accepting edge.
    task automatic send(input int v, input logic tw);
        @(negedge clk_in);
        doppler_ready = 1'b1;
        velocity_in   = 16'(v);
        towards_in    = tw;
        @(negedge clk_in);
        doppler_ready = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_avg"},   int'(avg_out), 0);
        chk({tag, "_valid"}, int'(avg_valid_out), 0);
        chk({tag, "_full"},  int'(full_out), 0);
        chk({tag, "_stale"}, int'(stale_out), 0);
        chk({tag, "_rej"},   int'(reject_cnt_out), 0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        chk_zero(tag);
        rst_in = 1'b0;
    endtask

    initial begin
        int exp_fill [8] = '{5, 10, 15, 20, 25, 30, 35, 40};

        do_reset("rst0");

        for (int i = 0; i < 4; i++) begin
            send(80, 1'b0);
        end
        chk("neg_avg", int'(avg_out), -40);
        chk("neg_full", int'(full_out), 0);

        do_reset("rst1");
        for (int i = 0; i < 8; i++) begin
            send(40, 1'b1);
            chk($sformatf("fill_valid%0d", i), int'(avg_valid_out), 1);
            chk($sformatf("fill_avg%0d", i), int'(avg_out), exp_fill[i]);
            chk($sformatf("fill_full%0d", i), int'(full_out), (i == 7) ? 1 : 0);
        end
        @(negedge clk_in);
        chk("valid_drop", int'(avg_valid_out), 0);
        chk("avg_hold", int'(avg_out), 40);

        for (int i = 0; i < 8; i++) begin
            send(20, 1'b1);
            if (i == 0) chk("wrap_avg1", int'(avg_out), 37);
            if (i == 3) chk("wrap_avg4", int'(avg_out), 30);
        end
        chk("wrap_avg8", int'(avg_out), 20);
        chk("wrap_full", int'(full_out), 1);

        repeat (1000) @(negedge clk_in);
        chk("pre_stale", int'(stale_out), 0);
        @(negedge clk_in);
        chk("stale_set", int'(stale_out), 1);
        chk("flush_avg", int'(avg_out), 0);
        chk("flush_full", int'(full_out), 0);
        doppler_ready = 1'b1;
        velocity_in   = 16'd100;
        towards_in    = 1'b1;
        @(negedge clk_in);
        doppler_ready = 1'b0;
        chk("flush_drop_valid", int'(avg_valid_out), 0);
        chk("flush_drop_avg", int'(avg_out), 0);
        repeat (10) @(negedge clk_in);
        chk("stale_hold", int'(stale_out), 1);
        send(40, 1'b1);
        chk("post_flush_avg", int'(avg_out), 5);
        chk("post_flush_valid", int'(avg_valid_out), 1);
        chk("stale_clr", int'(stale_out), 0);

        do_reset("rst_fill");

        repeat (1003) @(negedge clk_in);
        chk("stale_again", int'(stale_out), 1);
        do_reset("rst_flush");
        send(40, 1'b1);
        chk("after_rst_avg", int'(avg_out), 5);

        do_reset("rst2");
        for (int i = 0; i < 8; i++) begin
            send(40, 1'b1);
        end
        chk("steady40", int'(avg_out), 40);
`ifdef VELOCITY_OUTLIER_REJECT_EN
        send(200, 1'b1);
        chk("rej1_valid", int'(avg_valid_out), 0);
        chk("rej1_cnt", int'(reject_cnt_out), 1);
        chk("rej1_avg", int'(avg_out), 40);
        send(200, 1'b1);
        send(200, 1'b1);
        chk("rej3_cnt", int'(reject_cnt_out), 3);
        send(200, 1'b1);
        chk("rej4_valid", int'(avg_valid_out), 1);
        chk("rej4_avg", int'(avg_out), 60);
        chk("rej4_cnt", int'(reject_cnt_out), 3);
`else
        send(200, 1'b1);
        chk("big_valid", int'(avg_valid_out), 1);
        chk("big_avg", int'(avg_out), 60);
        chk("big_rej", int'(reject_cnt_out), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/velocity_filter.md
VELOCITY_FILTER -- requirements
Module: velocity_filter

Interface
REQ-001 SHALL have parameter DEPTH, default 8, power of two from 2 to 64, moving-average window length.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100_000_000, idle cycles without a new sample before the window is flushed.
REQ-003 SHALL have parameter OUTLIER_THRESH, default 50, the absolute deviation (m/s units) that marks a sample as an outlier.
REQ-004 SHALL use one clock and a synchronous active-high reset: clk_in in 1 system clock; rst_in in 1 synchronous active-high reset.
REQ-005 SHALL have port doppler_ready in 1: one-cycle strobe, new velocity sample present.
REQ-006 SHALL have port velocity_in in 16: unsigned speed magnitude.
REQ-007 SHALL have port towards_in in 1: direction; 1 = approaching.
REQ-008 SHALL have port avg_out out 17: signed moving average.
REQ-009 SHALL have port avg_valid_out out 1: one-cycle strobe, avg_out updated.
REQ-010 SHALL have port full_out out 1: window holds DEPTH real samples.
REQ-011 SHALL have port stale_out out 1: timeout expired, no recent data.
REQ-012 SHALL have port reject_cnt_out out 8: saturating count of rejected outliers.

Function
REQ-013 SHALL convert each sample to signed 17-bit s: s = +velocity_in when towards_in=1, else -velocity_in.
REQ-014 SHALL store samples in a DEPTH-entry circular buffer with write pointer wr_ptr, which wraps from DEPTH-1 to 0.
REQ-015 SHALL, on each accepted sample, do sum <= sum + s - buf[wr_ptr], write buf[wr_ptr] <= s, and advance wr_ptr.
REQ-016 SHALL keep sum at 17+log2(DEPTH) bits signed, which cannot overflow.
REQ-017 SHALL compute avg_out = sum >>> log2(DEPTH) (arithmetic shift), registered.
REQ-018 SHALL assert avg_valid_out exactly 1 cycle after the accepting doppler_ready, and never on a rejected or ignored sample.
REQ-019 SHALL use FSM states FILL, STEADY and FLUSH.
REQ-020 FILL: empty entries read as 0; a fill counter increments per accepted sample; at DEPTH accepted samples -> STEADY, with full_out=1 from that point.
REQ-021 STEADY: full_out=1; samples are accepted per REQ-015, or rejected per REQ-030.
REQ-022 SHALL count cycles since the last accepted sample with an idle counter; when it reaches TIMEOUT_CYCLES in FILL or STEADY -> FLUSH and stale_out <= 1.
REQ-023 FLUSH: clears one entry per cycle for DEPTH cycles, with sum, fill counter, wr_ptr and full_out set to 0; then -> FILL.
REQ-024 SHALL drop doppler_ready arriving during FLUSH with no output effect.
REQ-025 SHALL clear stale_out on the first sample accepted after a timeout.
REQ-026 SHALL give doppler_ready priority when it coincides with the idle counter reaching TIMEOUT_CYCLES: the sample is accepted, the counter clears, and no flush occurs.
REQ-027 SHALL hold the idle counter at 0 in FLUSH.
REQ-028 SHALL keep avg_out holding its last value between strobes; after a flush completes, avg_out SHALL be 0.

Reset
REQ-029 SHALL, on rst_in=1, set state FILL, all buffer entries, sum, wr_ptr, fill counter and idle counter 0, avg_out=0, avg_valid_out=0, full_out=0, stale_out=0, reject_cnt_out=0; reset mid-flush aborts the flush.

Configuration
REQ-030 SHALL, with VELOCITY_OUTLIER_REJECT_EN defined, reject in STEADY any sample with |s - avg_out| > OUTLIER_THRESH: no buffer write, reject_cnt_out increments (saturating at 255), and the idle counter is not cleared.
REQ-031 SHALL count consecutive rejects with a 2-bit counter; the 4th consecutive outlier is accepted and the counter clears; any accepted sample also clears it.
REQ-032 SHALL, without VELOCITY_OUTLIER_REJECT_EN, accept every sample outside FLUSH and tie reject_cnt_out to 0.

Structure
REQ-033 SHALL define in shared package velocity_pkg: the FSM state enum, VEL_W=17, and the signed velocity typedef.
REQ-034 SHALL implement buffer storage plus pointer wrap as sub-module vel_ring_buffer, with the sum arithmetic kept in the parent.

Verification (DEPTH=8, OUTLIER_THRESH=50, TIMEOUT_CYCLES=1000)
REQ-035 SHALL cover: 8 samples v=40, towards=1 -> after the 8th, avg_out=40, full_out=1, and avg_valid_out 1 cycle after each strobe.
REQ-036 SHALL cover: 4 samples v=80, towards=0 from reset -> avg_out=-40, full_out=0.
REQ-037 SHALL cover: steady at 40, then 8 samples v=20, towards=1 -> final avg_out=20, wr_ptr wraps without glitch.
REQ-038 SHALL cover: no samples for 1000 cycles -> stale_out=1, 8 flush cycles, avg_out=0; a sample during flush is ignored; the next sample clears stale_out.
REQ-039 SHALL cover, with the macro: steady at 40, sample 200 -> rejected, reject_cnt_out=1, no avg_valid_out; four 200s -> the 4th is accepted, avg_out=60.
REQ-040 SHALL cover: assert rst_in mid-FLUSH and mid-FILL -> all outputs 0 on the next cycle.
